// File: rtl/text_row_buffer.sv
// -----------------------------------------------------------------------------
// text_row_buffer
//
// Ping-pong character row store in the pixel clock domain. Sits between the
// 16-bit FIFO read adapter (upstream) and the VGA text glyph decoder
// (downstream). One bank holds the text row being drawn for its 16 scanlines.
// The other bank is prefetched from the upstream FIFO in the background. A
// row-done strobe retires the drawn bank and makes the prefetched bank current.
//
// Ports
//   clk_i         pixel clock
//   pixel_rstn_i  asynchronous active-low reset
//   clear_i       synchronous frame restart, invalidates both banks
//   empty_i       upstream FIFO empty
//   re_o          upstream pop (combinational, one word per cycle)
//   rdata_i       upstream first-word-fall-through data
//   re_i          read strobe from the draw pipeline
//   char_idx_i    character column to read
//   pop_line_i    current row finished, retire the read bank
//   data_o        registered character word, one cycle after re_i
//   empty_o       read bank not valid
//   underrun_o    one-cycle pulse after a read or pop against an invalid bank
// -----------------------------------------------------------------------------
module text_row_buffer #(
    parameter int CHARS_PER_ROW = 80,
    parameter int DATA_W        = 16,
    parameter int IDX_W         = 8
) (
    input  logic              clk_i,
    input  logic              pixel_rstn_i,
    input  logic              clear_i,
    input  logic              empty_i,
    output logic              re_o,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  char_idx_i,
    input  logic              pop_line_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              underrun_o
);

    localparam int CNT_W  = $clog2(CHARS_PER_ROW + 1);
    localparam int ADDR_W = (CHARS_PER_ROW > 1) ? $clog2(CHARS_PER_ROW) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHARS_PER_ROW - 1);
    localparam logic [IDX_W:0]   ROW_LEN  = (IDX_W + 1)'(CHARS_PER_ROW);

    // Row storage: no reset, contents only become visible through valid.
    logic [DATA_W-1:0] bank_mem [2][CHARS_PER_ROW];

    logic [1:0]        valid;
    logic              rd_bank;
    logic              wr_bank;
    logic [CNT_W-1:0]  wr_cnt;

    logic [1:0]        valid_nxt;
    logic              rd_bank_nxt;
    logic              wr_bank_nxt;
    logic [CNT_W-1:0]  wr_cnt_nxt;

    logic              char_in_range;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data_p1;
    logic              underrun_p1;

    // Fill only into an invalid bank; when both banks hold rows, wr_bank
    // points at a valid bank and the fill naturally stalls.
    assign re_o    = ~empty_i & ~valid[wr_bank] & ~clear_i;
    assign empty_o = ~valid[rd_bank];

    always_ff @(posedge clk_i) begin
        if (re_o) begin
            bank_mem[wr_bank][wr_cnt[ADDR_W-1:0]] <= rdata_i;
        end
    end

    // Fill completion and pop may land together; they always touch different
    // banks because fill writes only into an invalid bank.
    always_comb begin
        valid_nxt   = valid;
        rd_bank_nxt = rd_bank;
        wr_bank_nxt = wr_bank;
        wr_cnt_nxt  = wr_cnt;
        if (clear_i) begin
            valid_nxt   = 2'b00;
            rd_bank_nxt = 1'b0;
            wr_bank_nxt = 1'b0;
            wr_cnt_nxt  = '0;
        end else begin
            if (re_o) begin
                if (wr_cnt == LAST_CNT) begin
                    valid_nxt[wr_bank] = 1'b1;
                    wr_bank_nxt        = ~wr_bank;
                    wr_cnt_nxt         = '0;
                end else begin
                    wr_cnt_nxt = wr_cnt + CNT_W'(1);
                end
            end
            if (pop_line_i && valid[rd_bank]) begin
                valid_nxt[rd_bank] = 1'b0;
                rd_bank_nxt        = ~rd_bank;
            end
        end
    end

    always_ff @(posedge clk_i or negedge pixel_rstn_i) begin
        if (!pixel_rstn_i) begin
            valid   <= 2'b00;
            rd_bank <= 1'b0;
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            valid   <= valid_nxt;
            rd_bank <= rd_bank_nxt;
            wr_bank <= wr_bank_nxt;
            wr_cnt  <= wr_cnt_nxt;
        end
    end

    assign char_in_range = ({1'b0, char_idx_i} < ROW_LEN);
    assign rd_word       = bank_mem[rd_bank][char_idx_i[ADDR_W-1:0]];

    // ---- stage p1: registered read word and underrun flag ----
    // Reads sample the pre-pop bank; a frame clear freezes data_o and
    // suppresses the underrun flag for that cycle.
    always_ff @(posedge clk_i or negedge pixel_rstn_i) begin
        if (!pixel_rstn_i) begin
            rd_data_p1  <= '0;
            underrun_p1 <= 1'b0;
        end else if (clear_i) begin
            underrun_p1 <= 1'b0;
        end else begin
            underrun_p1 <= (re_i | pop_line_i) & ~valid[rd_bank];
            if (re_i) begin
                rd_data_p1 <= (valid[rd_bank] && char_in_range) ? rd_word : '0;
            end
        end
    end

    assign data_o     = rd_data_p1;
    assign underrun_o = underrun_p1;

endmodule
